// File: rtl/alkloop.sv
// ALK multiply/divide step-loop controller: sequences MUL/DIV/DIVDBL/REM iterations and owns
// the LOOPF/ALUSO flags. Optional abort input enabled by defining ALKLOOP_ABORT_EN.
module alkloop #(
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned MAX_STEPS = 32
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             ustep_en_h,
    input  logic             loop_start_h,
    input  logic [CNT_W-1:0] loop_cnt_ld_h,
    input  logic             alpctl_mul_l,
    input  logic             alpctl_div_l,
    input  logic             alpctl_divdbl_l,
    input  logic             alpctl_rem_l,
    input  logic             alu_sout_shl_h,
    input  logic             q_sout_shr_h,
    input  logic             c32_out_h,
`ifdef ALKLOOP_ABORT_EN
    input  logic             loop_abort_h,
`endif
    output logic             loopf_h,
    output logic             aluso_h,
    output logic             loop_busy_h,
    output logic             loop_last_h,
    output logic             loop_done_h
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;
    typedef enum logic [2:0] {ModeNone, ModeShift, ModeMul, ModeDiv, ModeDivDbl, ModeRem} mode_e;

    localparam logic [CNT_W-1:0] MaxLd = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] One   = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, start_mode;
    logic [CNT_W-1:0] cnt_q, cnt_d, ld_clamped;
    logic             loopf_q, loopf_d;
    logic             aluso_q, aluso_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             abort_req;

`ifdef ALKLOOP_ABORT_EN
    assign abort_req = loop_abort_h;
`else
    assign abort_req = 1'b0;
`endif

    assign ld_clamped = (loop_cnt_ld_h > MaxLd) ? MaxLd : loop_cnt_ld_h;

    always_comb begin
        start_mode = ModeShift;
        if (!alpctl_mul_l) begin
            start_mode = ModeMul;
        end else if (!alpctl_div_l) begin
            start_mode = ModeDiv;
        end else if (!alpctl_divdbl_l) begin
            start_mode = ModeDivDbl;
        end else if (!alpctl_rem_l) begin
            start_mode = ModeRem;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        loopf_d = loopf_q;
        aluso_d = aluso_q;
        if (ustep_en_h) begin
            unique case (state_q)
                StIdle: begin
                    if (loop_start_h) begin
                        mode_d  = start_mode;
                        cnt_d   = ld_clamped;
                        aluso_d = 1'b0;
                        loopf_d = (start_mode == ModeMul) ? q_sout_shr_h : 1'b0;
                        state_d = (ld_clamped == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (abort_req) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        loopf_d = 1'b0;
                        aluso_d = 1'b0;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - One;
                        end
                        aluso_d = alu_sout_shl_h;
                        unique case (mode_q)
                            ModeMul:                       loopf_d = q_sout_shr_h;
                            ModeDiv, ModeDivDbl, ModeRem:  loopf_d = c32_out_h;
                            default:                       loopf_d = 1'b0;
                        endcase
                        // cnt==0 here is unreachable; treated like the final step so it can't stick
                        if (cnt_q <= One) begin
                            state_d = (mode_q == ModeDivDbl || mode_q == ModeRem) ? StFix : StDone;
                        end
                    end
                end
                StFix: begin
                    if (abort_req) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        loopf_d = 1'b0;
                        aluso_d = 1'b0;
                    end else begin
                        loopf_d = c32_out_h;
                        state_d = StDone;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d == StRun) || (state_d == StFix);
        last_d = (state_d == StRun) && (cnt_d == One);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_q <= StIdle;
            mode_q  <= ModeNone;
            cnt_q   <= '0;
            loopf_q <= 1'b0;
            aluso_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            loopf_q <= loopf_d;
            aluso_q <= aluso_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign loopf_h     = loopf_q;
    assign aluso_h     = aluso_q;
    assign loop_busy_h = busy_q;
    assign loop_last_h = last_q;
    assign loop_done_h = done_q;

endmodule

// File: tb/tb_alkloop.sv
// Scoreboard bench for alkloop: stimulus pushes expected end-of-loop flags and busy length,
// a negedge monitor pops and compares on every loop_done_h pulse.
module tb_alkloop;

    logic       clk_h = 1'b0;
    logic       reset_h;
    logic       ustep_en_h;
    logic       loop_start_h;
    logic [5:0] loop_cnt_ld_h;
    logic       alpctl_mul_l, alpctl_div_l, alpctl_divdbl_l, alpctl_rem_l;
    logic       alu_sout_shl_h, q_sout_shr_h, c32_out_h;
    logic       loop_abort_h;
    logic       loopf_h, aluso_h, loop_busy_h, loop_last_h, loop_done_h;

    typedef struct packed {
        logic       loopf;
        logic       aluso;
        logic [7:0] busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;

    always #5 clk_h = ~clk_h;

    alkloop dut (
        .clk_h          (clk_h),
        .reset_h        (reset_h),
        .ustep_en_h     (ustep_en_h),
        .loop_start_h   (loop_start_h),
        .loop_cnt_ld_h  (loop_cnt_ld_h),
        .alpctl_mul_l   (alpctl_mul_l),
        .alpctl_div_l   (alpctl_div_l),
        .alpctl_divdbl_l(alpctl_divdbl_l),
        .alpctl_rem_l   (alpctl_rem_l),
        .alu_sout_shl_h (alu_sout_shl_h),
        .q_sout_shr_h   (q_sout_shr_h),
        .c32_out_h      (c32_out_h),
`ifdef ALKLOOP_ABORT_EN
        .loop_abort_h   (loop_abort_h),
`endif
        .loopf_h        (loopf_h),
        .aluso_h        (aluso_h),
        .loop_busy_h    (loop_busy_h),
        .loop_last_h    (loop_last_h),
        .loop_done_h    (loop_done_h)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    // 0 shift, 1 mul, 2 div, 3 divdbl, 4 rem
    task automatic set_mode(input int m);
        alpctl_mul_l    = (m != 1);
        alpctl_div_l    = (m != 2);
        alpctl_divdbl_l = (m != 3);
        alpctl_rem_l    = (m != 4);
    endtask

    task automatic chk_outs(input string name, input int f, input int s, input int b,
                            input int l, input int d);
        chk({name, "_loopf"}, int'(loopf_h), f);
        chk({name, "_aluso"}, int'(aluso_h), s);
        chk({name, "_busy"}, int'(loop_busy_h), b);
        chk({name, "_last"}, int'(loop_last_h), l);
        chk({name, "_done"}, int'(loop_done_h), d);
    endtask

    task automatic push(input logic f, input logic s, input int b);
        exp_t e;
        e.loopf = f;
        e.aluso = s;
        e.busy  = 8'(b);
        sb.push_back(e);
    endtask

    always @(negedge clk_h) begin
        if (loop_done_h) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with no loop outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_loopf", int'(loopf_h), int'(e.loopf));
                chk("done_aluso", int'(aluso_h), int'(e.aluso));
                chk("done_busy_len", run_len, int'(e.busy));
            end
            run_len = 0;
        end else if (loop_busy_h) begin
            run_len++;
        end else begin
            run_len = 0;
        end
    end

    logic qv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic av[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic rc[3] = '{1'b1, 1'b1, 1'b0};
    logic ra[3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        reset_h = 1'b1; ustep_en_h = 1'b1; loop_start_h = 1'b0; loop_cnt_ld_h = '0;
        set_mode(0);
        alu_sout_shl_h = 1'b0; q_sout_shr_h = 1'b0; c32_out_h = 1'b0; loop_abort_h = 1'b0;
        tick(); tick();
        chk_outs("reset", 0, 0, 0, 0, 0);
        reset_h = 1'b0;
        tick();

        // Reset mid-RUN with cnt=5
        set_mode(1); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd8; q_sout_shr_h = 1'b1;
        alu_sout_shl_h = 1'b1;
        tick();
        loop_start_h = 1'b0;
        repeat (3) tick();
        chk("midrun_busy", int'(loop_busy_h), 1);
        chk("midrun_aluso", int'(aluso_h), 1);
        reset_h = 1'b1;
        tick();
        chk_outs("midreset", 0, 0, 0, 0, 0);
        reset_h = 1'b0; q_sout_shr_h = 1'b0; alu_sout_shl_h = 1'b0; set_mode(0);
        tick();
        chk("post_reset_busy", int'(loop_busy_h), 0);

        // MUL ld=4
        set_mode(1); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd4; q_sout_shr_h = 1'b1;
        push(1'b0, 1'b1, 4);
        tick();
        chk("mul_start_loopf", int'(loopf_h), 1);
        chk("mul_start_aluso", int'(aluso_h), 0);
        loop_start_h = 1'b0; set_mode(4);
        for (int i = 0; i < 4; i++) begin
            q_sout_shr_h = qv[i]; alu_sout_shl_h = av[i];
            tick();
            chk("mul_loopf", int'(loopf_h), int'(qv[i]));
            chk("mul_last", int'(loop_last_h), (i == 2) ? 1 : 0);
        end
        chk("mul_done", int'(loop_done_h), 1);
        // start in the DONE clock must be ignored
        loop_start_h = 1'b1; loop_cnt_ld_h = 6'd1; set_mode(0);
        tick();
        chk("done_start_ignored", int'(loop_busy_h), 0);
        chk("done_one_pulse", int'(loop_done_h), 0);
        loop_start_h = 1'b0;
        tick();

        // REM ld=3: 3 RUN + FIX
        set_mode(4); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd3; c32_out_h = 1'b1;
        q_sout_shr_h = 1'b1;
        push(1'b1, 1'b1, 4);
        tick();
        chk("rem_start_loopf", int'(loopf_h), 0);
        loop_start_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c32_out_h = rc[i]; alu_sout_shl_h = ra[i];
            tick();
            chk("rem_loopf", int'(loopf_h), int'(rc[i]));
        end
        chk("rem_fix_busy", int'(loop_busy_h), 1);
        c32_out_h = 1'b1; alu_sout_shl_h = 1'b0;
        tick();
        c32_out_h = 1'b0;
        tick();
        tick();

        // ld=0: done next clock, never busy
        set_mode(0); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd0; q_sout_shr_h = 1'b1;
        push(1'b0, 1'b0, 0);
        tick();
        chk("ld0_done", int'(loop_done_h), 1);
        chk("ld0_busy", int'(loop_busy_h), 0);
        loop_start_h = 1'b0;
        tick();

        // ld=63 clamps to 32 steps
        loop_start_h = 1'b1; loop_cnt_ld_h = 6'd63;
        push(1'b0, 1'b1, 32);
        tick();
        loop_start_h = 1'b0;
        for (int i = 0; i < 32; i++) begin
            alu_sout_shl_h = (i == 31);
            tick();
            if (i == 30) chk("clamp_last", int'(loop_last_h), 1);
        end
        chk("clamp_done", int'(loop_done_h), 1);
        alu_sout_shl_h = 1'b0;
        tick();

        // DIV ld=2 with a 3-clock stall and ignored starts
        set_mode(2); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd2; c32_out_h = 1'b0;
        push(1'b1, 1'b0, 5);
        tick();
        c32_out_h = 1'b1; alu_sout_shl_h = 1'b1; loop_cnt_ld_h = 6'd9;
        tick();
        ustep_en_h = 1'b0; c32_out_h = 1'b0; alu_sout_shl_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("stall", 1, 1, 1, 1, 0);
        end
        ustep_en_h = 1'b1; c32_out_h = 1'b1;
        tick();
        loop_start_h = 1'b0;
        tick();
        chk("div_after_busy", int'(loop_busy_h), 0);
        c32_out_h = 1'b0;

`ifdef ALKLOOP_ABORT_EN
        // abort at cnt==1 in DIVDBL: no FIX, no done
        set_mode(3); loop_start_h = 1'b1; loop_cnt_ld_h = 6'd2;
        tick();
        loop_start_h = 1'b0; c32_out_h = 1'b1; alu_sout_shl_h = 1'b1;
        tick();
        chk("abort_pre_last", int'(loop_last_h), 1);
        loop_abort_h = 1'b1;
        tick();
        loop_abort_h = 1'b0;
        chk_outs("abort", 0, 0, 0, 0, 0);
        tick();
        chk("abort_no_done", int'(loop_done_h), 0);
        c32_out_h = 1'b0; alu_sout_shl_h = 1'b0;
`endif

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
